// File: rtl/rsa_avm_stream_bridge.sv
// Avalon-MM master that streams key/ciphertext bytes from a UART-style byte port
// into an external RSA modexp core and writes the result bytes back out.
module rsa_avm_stream_bridge #(
    parameter int unsigned BITWIDTH    = 256,
    parameter int unsigned OUT_BYTES   = BITWIDTH / 8 - 1,
    parameter int unsigned KEY_REUSE   = 1,
    parameter int unsigned RX_BASE     = 0,
    parameter int unsigned TX_BASE     = 4,
    parameter int unsigned STATUS_BASE = 8,
    parameter int unsigned RX_OK_BIT   = 7,
    parameter int unsigned TX_OK_BIT   = 6
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                o_core_start,
    output logic [BITWIDTH-1:0] o_core_a,
    output logic [BITWIDTH-1:0] o_core_d,
    output logic [BITWIDTH-1:0] o_core_n,
    input  logic [BITWIDTH-1:0] i_core_result,
    input  logic                i_core_finished,
    input  logic                i_rekey,
    output logic                o_busy,
    output logic [15:0]         o_block_cnt
);

    localparam int unsigned AW     = 5;
    localparam int unsigned NBYTES = BITWIDTH / 8;
    localparam int unsigned CW     = $clog2(NBYTES + 1);

    localparam logic [2:0] S_GET_N    = 3'd0;
    localparam logic [2:0] S_GET_D    = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_SEND     = 3'd5;

    localparam logic [0:0] IO_POLL = 1'b0;
    localparam logic [0:0] IO_XFER = 1'b1;

    logic [2:0]          state, state_d;
    logic [0:0]          io, io_d;
    logic [CW-1:0]       byte_cnt, byte_cnt_d;
    logic [BITWIDTH-1:0] dec, dec_d;
    logic [BITWIDTH-1:0] n_d, d_d, a_d;
    logic                rekey_flag, rekey_d;
    logic                read_d, write_d, start_d, busy_d;
    logic [AW-1:0]       addr_d;
    logic [31:0]         wdata_d;
    logic [15:0]         blk_d;
    logic                ok_bit, rx_last, tx_last;
    logic [7:0]          tx_byte;
    logic                unused_rdata;

    // Only the low data byte and the two status flags are meaningful on readdata.
    assign unused_rdata = ^avm_readdata;

    // All state and registered outputs.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state         <= S_GET_N;
            io            <= IO_POLL;
            byte_cnt      <= '0;
            dec           <= '0;
            o_core_n      <= '0;
            o_core_d      <= '0;
            o_core_a      <= '0;
            rekey_flag    <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= AW'(STATUS_BASE);
            avm_writedata <= '0;
            o_core_start  <= 1'b0;
            o_busy        <= 1'b0;
            o_block_cnt   <= '0;
        end else begin
            state         <= state_d;
            io            <= io_d;
            byte_cnt      <= byte_cnt_d;
            dec           <= dec_d;
            o_core_n      <= n_d;
            o_core_d      <= d_d;
            o_core_a      <= a_d;
            rekey_flag    <= rekey_d;
            avm_read      <= read_d;
            avm_write     <= write_d;
            avm_address   <= addr_d;
            avm_writedata <= wdata_d;
            o_core_start  <= start_d;
            o_busy        <= busy_d;
            o_block_cnt   <= blk_d;
        end
    end

    // Next-state: top sequencer plus the poll/transfer byte engine.
    always_comb begin
        state_d    = state;
        io_d       = io;
        byte_cnt_d = byte_cnt;
        dec_d      = dec;
        n_d        = o_core_n;
        d_d        = o_core_d;
        a_d        = o_core_a;
        read_d     = avm_read;
        write_d    = avm_write;
        addr_d     = avm_address;
        wdata_d    = avm_writedata;
        start_d    = 1'b0;
        blk_d      = o_block_cnt;
        rekey_d    = rekey_flag | i_rekey;
        ok_bit     = 1'b0;
        rx_last    = (byte_cnt == CW'(NBYTES - 1));
        tx_last    = (byte_cnt == CW'(OUT_BYTES - 1));
        tx_byte    = 8'(dec >> (8 * (OUT_BYTES - 1 - 32'(byte_cnt))));

        case (state)
            S_GET_N, S_GET_D, S_GET_DATA, S_SEND: begin
                if (io == IO_POLL) begin
                    if (!avm_read) begin
                        read_d = 1'b1;
                        addr_d = AW'(STATUS_BASE);
                    end else if (!avm_waitrequest) begin
                        read_d = 1'b0;
                        ok_bit = (state == S_SEND) ? avm_readdata[TX_OK_BIT]
                                                   : avm_readdata[RX_OK_BIT];
                        if (ok_bit) begin
                            io_d = IO_XFER;
                        end
                    end
                end else if (!avm_read && !avm_write) begin
                    if (state == S_SEND) begin
                        write_d = 1'b1;
                        addr_d  = AW'(TX_BASE);
                        wdata_d = {24'd0, tx_byte};
                    end else begin
                        read_d = 1'b1;
                        addr_d = AW'(RX_BASE);
                    end
                end else if (!avm_waitrequest) begin
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    addr_d     = AW'(STATUS_BASE);
                    io_d       = IO_POLL;
                    byte_cnt_d = byte_cnt + CW'(1);
                    case (state)
                        S_GET_N:    n_d = {o_core_n[BITWIDTH-9:0], avm_readdata[7:0]};
                        S_GET_D:    d_d = {o_core_d[BITWIDTH-9:0], avm_readdata[7:0]};
                        S_GET_DATA: a_d = {o_core_a[BITWIDTH-9:0], avm_readdata[7:0]};
                        default:    ;
                    endcase
                    if (state == S_SEND) begin
                        if (tx_last) begin
                            byte_cnt_d = '0;
                            blk_d      = o_block_cnt + 16'd1;
                            state_d    = ((KEY_REUSE != 0) && !rekey_flag) ? S_GET_DATA : S_GET_N;
                        end
                    end else if (rx_last) begin
                        byte_cnt_d = '0;
                        case (state)
                            S_GET_N: state_d = S_GET_D;
                            S_GET_D: state_d = S_GET_DATA;
                            default: begin
                                state_d = S_START;
                                start_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_core_finished) begin
                    dec_d   = i_core_result;
                    state_d = S_SEND;
                end
            end
            default: state_d = S_GET_N;
        endcase

        // Entering key load consumes the pending rekey request.
        if ((state_d == S_GET_N) && (state != S_GET_N)) begin
            rekey_d = i_rekey;
        end

        busy_d = !(((state_d == S_GET_N) || (state_d == S_GET_DATA)) &&
                   (byte_cnt_d == '0) && (io_d == IO_POLL));
    end

endmodule

// File: tb/tb_rsa_avm_stream_bridge.sv
// Randomized bench: Avalon slave with random stalls, byte-stream model and core model.
module tb_rsa_avm_stream_bridge;

    localparam int BW = 32;
    localparam int OB = 3;
    localparam int NB = BW / 8;

    logic          avm_clk = 1'b0;
    logic          avm_rst;
    logic [4:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic          o_core_start;
    logic [BW-1:0] o_core_a, o_core_d, o_core_n;
    logic [BW-1:0] i_core_result;
    logic          i_core_finished;
    logic          i_rekey;
    logic          o_busy;
    logic [15:0]   o_block_cnt;

    rsa_avm_stream_bridge #(.BITWIDTH(BW), .OUT_BYTES(OB), .KEY_REUSE(1)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address),
        .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d),
        .o_core_n(o_core_n), .i_core_result(i_core_result),
        .i_core_finished(i_core_finished), .i_rekey(i_rekey), .o_busy(o_busy),
        .o_block_cnt(o_block_cnt)
    );

    always #5 avm_clk = ~avm_clk;

    // Byte streams: rx written by the stimulus, consumed by the slave; tx logged by the slave.
    logic [7:0]  rx_mem [0:1023];
    logic [7:0]  tx_log [0:1023];
    int          rx_wr = 0, rx_rd = 0, tx_cnt = 0;
    int          rx_reads = 0, status_reads = 0, start_cnt = 0;
    int          hold_viol = 0, rw_viol = 0, bad_addr = 0;
    int          spur_req = 0, spur_done = 0, force3_req = 0, force3_done = 0;
    logic [23:0] tx_upper = '0;
    logic [BW-1:0] exp_r, cap_n, cap_d, cap_a;
    logic [BW-1:0] model_n = '0, model_d = '0;
    int          lat = 0, wait_left = 0, exp_blk = 0;
    bit          in_txn = 0, prev_wait = 0, need_key = 1;
    logic        p_read, p_write;
    logic [4:0]  p_addr;
    logic [31:0] p_wdata, tmp;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave, core model and bus-rule monitor, all acting on the falling edge.
    always @(negedge avm_clk) begin
        i_core_finished = 1'b0;
        if (avm_rst) begin
            lat = 0; in_txn = 0; prev_wait = 0;
            avm_waitrequest = 1'b0; avm_readdata = '0; i_core_result = '0;
        end else begin
            if (o_core_start) begin
                start_cnt++;
                cap_n = o_core_n; cap_d = o_core_d; cap_a = o_core_a;
                lat = $urandom_range(1, 5);
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    i_core_finished = 1'b1;
                    i_core_result   = exp_r;
                end
            end else if (spur_done != spur_req) begin
                spur_done++;
                i_core_finished = 1'b1;
                i_core_result   = ~exp_r;
            end

            if (prev_wait && (avm_read !== p_read || avm_write !== p_write ||
                              avm_address !== p_addr || (avm_write && avm_writedata !== p_wdata)))
                hold_viol++;
            if (avm_read && avm_write) rw_viol++;

            if (!(avm_read || avm_write)) begin
                in_txn = 0;
            end else if (!in_txn) begin
                in_txn = 1;
                if (force3_req != force3_done && avm_read && avm_address == 5'd0) begin
                    force3_done++;
                    wait_left = 3;
                end else begin
                    wait_left = $urandom_range(0, 2);
                end
            end

            if (in_txn && wait_left > 0) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                wait_left--;
            end else begin
                avm_waitrequest = 1'b0;
                if (in_txn) begin
                    if (avm_read && avm_address == 5'd8) begin
                        status_reads++;
                        tmp    = $urandom;
                        tmp[7] = (rx_wr != rx_rd);
                        tmp[6] = ($urandom_range(0, 3) != 0);
                        avm_readdata = tmp;
                    end else if (avm_read && avm_address == 5'd0) begin
                        rx_reads++;
                        tmp      = $urandom;
                        tmp[7:0] = rx_mem[10'(rx_rd)];
                        avm_readdata = tmp;
                        rx_rd++;
                    end else if (avm_write && avm_address == 5'd4) begin
                        tx_log[10'(tx_cnt)] = avm_writedata[7:0];
                        tx_upper = tx_upper | avm_writedata[31:8];
                        tx_cnt++;
                    end else begin
                        bad_addr++;
                    end
                end
            end
            p_read = avm_read; p_write = avm_write; p_addr = avm_address; p_wdata = avm_writedata;
            prev_wait = avm_waitrequest && (avm_read || avm_write);
        end
    end

    task automatic push_word(input logic [BW-1:0] w);
        for (int i = 0; i < NB; i++) begin
            rx_mem[10'(rx_wr)] = 8'(w >> (8 * (NB - 1 - i)));
            rx_wr++;
        end
    endtask

    task automatic wait_tx(input int target);
        int budget = 0;
        while (tx_cnt < target && budget < 4000) begin
            @(posedge avm_clk);
            budget++;
        end
        chk("tx_timeout", 64'(tx_cnt >= target), 64'd1);
    endtask

    // One block: optional key, ciphertext, expected result bytes and counters.
    task automatic run_block(input bit with_key, input logic [BW-1:0] n, d, c, r, input bit rekey);
        int rx0 = rx_reads, tx0 = tx_cnt, st0 = start_cnt;
        if (with_key) begin
            model_n = n; model_d = d;
            push_word(n); push_word(d);
        end
        exp_r = r;
        push_word(c);
        if (rekey) begin
            @(negedge avm_clk); i_rekey = 1'b1;
            @(negedge avm_clk); i_rekey = 1'b0;
            need_key = 1;
        end
        wait_tx(tx0 + OB);
        repeat (2) @(posedge avm_clk);
        #1;
        exp_blk++;
        chk("start_pulses", 64'(start_cnt - st0), 64'd1);
        chk("core_n", 64'(cap_n), 64'(model_n));
        chk("core_d", 64'(cap_d), 64'(model_d));
        chk("core_a", 64'(cap_a), 64'(c));
        chk("rx_bytes", 64'(rx_reads - rx0), with_key ? 64'(3 * NB) : 64'(NB));
        for (int k = 0; k < OB; k++)
            chk("tx_byte", 64'(tx_log[10'(tx0 + k)]), 64'(8'(r >> (8 * (OB - 1 - k)))));
        chk("block_cnt", 64'(o_block_cnt), 64'(exp_blk));
    endtask

    initial begin
        int s0, tx0;
        bit wk;
        avm_rst = 1'b1;
        i_rekey = 1'b0;
        repeat (3) @(negedge avm_clk);
        chk("rst_read", 64'(avm_read), 64'd0);
        chk("rst_write", 64'(avm_write), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd8);
        chk("rst_wdata", 64'(avm_writedata), 64'd0);
        chk("rst_start", 64'(o_core_start), 64'd0);
        chk("rst_blk", 64'(o_block_cnt), 64'd0);
        chk("rst_core_n", 64'(o_core_n), 64'd0);
        avm_rst = 1'b0;

        // No RX data for 50 cycles: only status polling, idle, stray strobe ignored.
        s0 = status_reads;
        spur_req++;
        repeat (50) @(negedge avm_clk);
        chk("idle_rx_reads", 64'(rx_reads), 64'd0);
        chk("idle_polls", 64'(status_reads > s0 + 5), 64'd1);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("idle_blk", 64'(o_block_cnt), 64'd0);

        // Directed block with a 3-cycle stall on the first RX read.
        force3_req = 1;
        need_key = 0;
        run_block(1'b1, 32'h0000_00BB, 32'h0000_0007, 32'h0000_0042, 32'h0012_3456, 1'b0);
        chk("stall_hit", 64'(force3_done), 64'd1);

        // Random blocks with key reuse and occasional rekey requests.
        for (int b = 0; b < 7; b++) begin
            wk = need_key;
            need_key = 0;
            run_block(wk, $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 2) == 0));
        end

        // Reset while results are being sent.
        wk = need_key;
        need_key = 0;
        tx0 = tx_cnt;
        if (wk) begin
            push_word($urandom); push_word($urandom);
        end
        exp_r = $urandom;
        push_word($urandom);
        wait_tx(tx0 + 2);
        @(negedge avm_clk);
        avm_rst = 1'b1;
        #1;
        chk("mid_rst_read", 64'(avm_read), 64'd0);
        chk("mid_rst_write", 64'(avm_write), 64'd0);
        chk("mid_rst_addr", 64'(avm_address), 64'd8);
        chk("mid_rst_blk", 64'(o_block_cnt), 64'd0);
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        rx_wr = rx_rd;
        exp_blk = 0;
        model_n = '0; model_d = '0;
        run_block(1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0);

        chk("hold_rule", 64'(hold_viol), 64'd0);
        chk("rw_exclusive", 64'(rw_viol), 64'd0);
        chk("bad_address", 64'(bad_addr), 64'd0);
        chk("wdata_upper", 64'(tx_upper), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
